// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: walks DIGIT-bit digits from the MSB down and stops at
// the first differing digit. Signed compare is done by flipping the sign bits at capture.
module seq_mag_comp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned KW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned NSLOT = 1 << KW;

  if (WIDTH < 2) begin : gen_bad_width
    $error("seq_mag_comp: WIDTH must be at least 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : gen_bad_digit
    $error("seq_mag_comp: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic {StIdle, StCmp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic [WIDTH-1:0] sign_mask;
  assign sign_mask = {sgn, {(WIDTH-1){1'b0}}};

  // Digit table padded to a power of two so k_q indexes it without width games.
  logic [DIGIT-1:0] dig_a [NSLOT];
  logic [DIGIT-1:0] dig_b [NSLOT];

  for (genvar i = 0; i < NSLOT; i++) begin : gen_digits
    if (i < NDIG) begin : gen_real
      assign dig_a[i] = a_q[i*DIGIT +: DIGIT];
      assign dig_b[i] = b_q[i*DIGIT +: DIGIT];
    end else begin : gen_pad
      assign dig_a[i] = '0;
      assign dig_b[i] = '0;
    end
  end

  logic [DIGIT-1:0] cur_a, cur_b;
  assign cur_a = dig_a[k_q];
  assign cur_b = dig_b[k_q];

  // State register and captured datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Offset-binary mapping makes the unsigned digit walk yield signed order.
          a_d     = a ^ sign_mask;
          b_d     = b ^ sign_mask;
          k_d     = KW'(NDIG - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (cur_a > cur_b) begin
          gt_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cur_a < cur_b) begin
          lt_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (k_q == '0) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy    = (state_q == StCmp);
    done    = done_q;
    greater = gt_q;
    less    = lt_q;
    equal   = eq_q;
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp (WIDTH=8, DIGIT=2) with hand-computed results and latencies.
module tb_seq_mag_comp;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sgn;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy, done, greater, less, equal;

  int total = 0;
  int bad   = 0;
  int cyc;

  seq_mag_comp #(.WIDTH(8), .DIGIT(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .greater (greater),
    .less    (less),
    .equal   (equal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic g, input logic l, input logic e);
    chk({tag, "_gt"}, greater, g);
    chk({tag, "_lt"}, less, l);
    chk({tag, "_eq"}, equal, e);
  endtask

  // Drive start for one edge; returns just after the capturing edge.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vs);
    a = va; b = vb; sgn = vs; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done, starting from c0 edges already elapsed since the start edge.
  task automatic wait_done(input int c0, output int n);
    n = c0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    chk("done_seen", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_flags("rst", 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Top digit decides: 11 vs 00.
    issue(8'hC0, 8'h3F, 1'b0);
    chk("c0_busy", busy, 1);
    wait_done(0, cyc);
    chk("c0_cyc", cyc, 1);
    chk("c0_busy_at_done", busy, 0);
    chk_flags("c0", 1, 0, 0);
    tick();
    chk("c0_done_width", done, 0);
    tick();
    chk("idle_done", done, 0);
    chk_flags("idle_hold", 1, 0, 0);

    // Full equality; operand change and a stray start while busy must be ignored.
    issue(8'h5A, 8'h5A, 1'b0);
    a = 8'h00;
    tick();
    chk("eq_busy1", busy, 1);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    tick();
    start = 1'b0;
    chk("eq_busy2", busy, 1);
    wait_done(2, cyc);
    chk("eq_cyc", cyc, 4);
    chk_flags("eq", 0, 0, 1);
    tick();
    chk("eq_done_width", done, 0);

    // Signed: -128 < 1.
    issue(8'h80, 8'h01, 1'b1);
    wait_done(0, cyc);
    chk("s_cyc", cyc, 1);
    chk_flags("s", 0, 1, 0);
    tick();

    // Unsigned: 128 > 1.
    issue(8'h80, 8'h01, 1'b0);
    wait_done(0, cyc);
    chk("u_cyc", cyc, 1);
    chk_flags("u", 1, 0, 0);
    tick();

    // Last digit decides, then back-to-back start in the done cycle.
    issue(8'h12, 8'h13, 1'b0);
    wait_done(0, cyc);
    chk("lt_cyc", cyc, 4);
    a = 8'hFF; b = 8'hFE; sgn = 1'b0; start = 1'b1;
    #1;
    chk_flags("lt_hold", 0, 1, 0);
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    chk_flags("b2b_clr", 0, 0, 0);
    wait_done(0, cyc);
    chk("b2b_cyc", cyc, 4);
    chk_flags("b2b", 1, 0, 0);
    tick();

    // Asynchronous reset mid-compare aborts with no done pulse.
    issue(8'h00, 8'h00, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk_flags("arst", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_done", done, 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_done", done, 0);
    issue(8'h01, 8'h00, 1'b0);
    wait_done(0, cyc);
    chk("post_cyc", cyc, 4);
    chk_flags("post", 1, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
